bin2decs_converter: RTL

// - Sequential binary-to-BCD converter with leading-zero blanking; sits directly upstream of
//   the 4-digit 7-segment multiplexer and drives its 16-bit decs bus (4 BCD nibbles, D4..D1).
// - Takes a binary value 0..9999 on a start handshake and runs shift-add-3 (double dabble),
//   one bit per clock.
// - Publishes a registered decs word that is held stable between conversions.
// - Blanked digits and overflow use the display's off code 4'hf.

---
 rtl/display_pkg.sv | 13 +
 rtl/dabble_add3.sv | 9 +
 rtl/bin2decs_converter.sv | 98 +++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants and state encoding for the binary-to-BCD display front end.
package display_pkg;

   localparam logic [3:0] DIG_OFF = 4'hf;
   localparam int         DEC_MAX = 9999;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      BLANK
   } state_t;

endpackage

// File: rtl/dabble_add3.sv
// One double-dabble correction cell: nibbles of 5 or more get +3 before the next shift.
module dabble_add3 (
   input  logic [3:0] in,
   output logic [3:0] out
);

   assign out = (in >= 4'd5) ? in + 4'd3 : in;

endmodule

// File: rtl/bin2decs_converter.sv
// Sequential binary-to-BCD converter (one bit per clock) with leading-zero blanking,
// publishing a held 4-digit decs word for the 7-segment multiplexer.
module bin2decs_converter
   import display_pkg::*;
#(
   parameter int WIDTH    = 14,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] value,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic [15:0]      decs
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] bin;
   logic [15:0]      bcd;
   logic [15:0]      bcd_adj;
   logic [CNT_W-1:0] cnt;
   logic             ovf_i;

   for (genvar g = 0; g < 4; g++) begin : g_add3
      dabble_add3 u_add3 (
         .in  (bcd[g*4 +: 4]),
         .out (bcd_adj[g*4 +: 4])
      );
   end

   // Zeros above the first significant digit go dark; D1 always shows.
   function automatic logic [15:0] blank(input logic [15:0] b);
      logic [15:0] r;
      logic        lead;
      r    = b;
      lead = BLANK_LZ;
      for (int i = 3; i >= 1; i--) begin
         if (lead && (b[i*4 +: 4] == 4'd0)) begin
            r[i*4 +: 4] = DIG_OFF;
         end else begin
            lead = 1'b0;
         end
      end
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         ovf   <= 1'b0;
         decs  <= {4{DIG_OFF}};
         bin   <= '0;
         bcd   <= '0;
         cnt   <= '0;
         ovf_i <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  bin   <= value;
                  bcd   <= '0;
                  cnt   <= '0;
                  ovf_i <= (32'(value) > DEC_MAX);
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               bcd <= {bcd_adj[14:0], bin[WIDTH-1]};
               bin <= {bin[WIDTH-2:0], 1'b0};
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  state <= BLANK;
               end
            end
            BLANK: begin
               // Overflowed conversions still run to completion but publish all-off.
               decs  <= ovf_i ? {4{DIG_OFF}} : blank(bcd);
               ovf   <= ovf_i;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
